// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared types and encodings for the RV64I multicycle control unit.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [6:0] OP_ALU_R   = 7'b0110011;
    localparam logic [6:0] OP_ALU_RW  = 7'b0111011;
    localparam logic [6:0] OP_ALU_I   = 7'b0010011;
    localparam logic [6:0] OP_ALU_IW  = 7'b0011011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    localparam logic [1:0] SEL_DM    = 2'b00;
    localparam logic [1:0] SEL_ULA   = 2'b01;
    localparam logic [1:0] SEL_PC4   = 2'b10;
    localparam logic [1:0] SEL_PCIMM = 2'b11;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_ALU_R   = 4'd1,
        CLS_ALU_I   = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_JALR    = 4'd7,
        CLS_LUI     = 4'd8,
        CLS_AUIPC   = 4'd9,
        CLS_SYSTEM  = 4'd10
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/main_decoder.sv
`default_nettype none
// ============================================================================
// Module   : main_decoder
// Brief    : Combinational opcode to instruction-class lookup.
// Revision : 1.0 - initial release
// ============================================================================
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0]   i_opcode,
    output instr_class_t o_class
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OP_ALU_R, OP_ALU_RW: o_class = CLS_ALU_R;
            OP_ALU_I, OP_ALU_IW: o_class = CLS_ALU_I;
            OP_LOAD:             o_class = CLS_LOAD;
            OP_STORE:            o_class = CLS_STORE;
            OP_BRANCH:           o_class = CLS_BRANCH;
            OP_JAL:              o_class = CLS_JAL;
            OP_JALR:             o_class = CLS_JALR;
            OP_LUI:              o_class = CLS_LUI;
            OP_AUIPC:            o_class = CLS_AUIPC;
            OP_SYSTEM:           o_class = CLS_SYSTEM;
            default:             o_class = CLS_ILLEGAL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for
//            the RV64I datapath, with retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
    import ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        IR_load,
    output logic        WE_RF,
    output logic        WE_MEM,
    output logic [1:0]  RF_din_sel,
    output logic        ULA_din2_sel,
    output logic        load_pc,
    output logic        pc_next_sel,
    output logic        pc_adder_sel,
    output logic        halted,
    output logic [31:0] retired
);

    state_t       r_state;
    state_t       w_state_next;
    instr_class_t w_class;
    logic [31:0]  r_retired;

    main_decoder u_main_decoder (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (load_pc) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        IR_load      = 1'b0;
        WE_RF        = 1'b0;
        WE_MEM       = 1'b0;
        RF_din_sel   = SEL_DM;
        ULA_din2_sel = 1'b0;
        load_pc      = 1'b0;
        pc_next_sel  = 1'b0;
        pc_adder_sel = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_FETCH: begin
                IR_load      = 1'b1;
                w_state_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_class == CLS_ILLEGAL || w_class == CLS_SYSTEM) begin
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                ULA_din2_sel = (w_class != CLS_ALU_R) && (w_class != CLS_BRANCH);
                case (w_class)
                    CLS_BRANCH: begin
                        load_pc      = 1'b1;
                        pc_next_sel  = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    // Link write and PC load share this edge, so rd gets the old PC+4
                    CLS_JAL, CLS_JALR: begin
                        load_pc      = 1'b1;
                        pc_next_sel  = 1'b1;
                        WE_RF        = 1'b1;
                        RF_din_sel   = SEL_PC4;
                        pc_adder_sel = (w_class == CLS_JALR);
                        w_state_next = S_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        w_state_next = S_MEMORY;
                    end
                    CLS_ALU_R, CLS_ALU_I, CLS_LUI, CLS_AUIPC: begin
                        w_state_next = S_WRITEBACK;
                    end
                    default: begin
                        w_state_next = S_HALT;
                    end
                endcase
            end
            S_MEMORY: begin
                ULA_din2_sel = 1'b1;
                if (mem_ready) begin
                    if (w_class == CLS_STORE) begin
                        WE_MEM       = 1'b1;
                        load_pc      = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                WE_RF        = 1'b1;
                load_pc      = 1'b1;
                w_state_next = S_FETCH;
                case (w_class)
                    CLS_LOAD:  RF_din_sel = SEL_DM;
                    CLS_AUIPC: RF_din_sel = SEL_PCIMM;
                    default:   RF_din_sel = SEL_ULA;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase

        // Reset silences every control output immediately, not at the next edge
        if (!RST_N) begin
            IR_load      = 1'b0;
            WE_RF        = 1'b0;
            WE_MEM       = 1'b0;
            RF_din_sel   = SEL_DM;
            ULA_din2_sel = 1'b0;
            load_pc      = 1'b0;
            pc_next_sel  = 1'b0;
            pc_adder_sel = 1'b0;
            halted       = 1'b0;
        end
    end

    assign retired = RST_N ? r_retired : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Cycle-by-cycle vector table for control_unit plus wrap sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [6:0]  opcode = 7'b0110011;
    logic        mem_ready = 1'b1;
    logic        IR_load, WE_RF, WE_MEM, ULA_din2_sel, load_pc;
    logic        pc_next_sel, pc_adder_sel, halted;
    logic [1:0]  RF_din_sel;
    logic [31:0] retired;

    control_unit dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .IR_load      (IR_load),
        .WE_RF        (WE_RF),
        .WE_MEM       (WE_MEM),
        .RF_din_sel   (RF_din_sel),
        .ULA_din2_sel (ULA_din2_sel),
        .load_pc      (load_pc),
        .pc_next_sel  (pc_next_sel),
        .pc_adder_sel (pc_adder_sel),
        .halted       (halted),
        .retired      (retired)
    );

    always #5 CLK = ~CLK;

    // One row per clock cycle: inputs held for the cycle, outputs expected in it
    typedef struct {
        string       name;
        logic        rst_n;
        logic [6:0]  op;
        logic        mr;
        logic [9:0]  ctl;
        logic [31:0] ret;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_ret = 0;

    // {IR_load, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, pc_next_sel, pc_adder_sel, halted}
    function automatic logic [9:0] ctl(input logic ir, input logic werf, input logic wemem,
                                       input logic [1:0] sel, input logic ula, input logic lpc,
                                       input logic nsel, input logic asel, input logic halt);
        return {ir, werf, wemem, sel, ula, lpc, nsel, asel, halt};
    endfunction

    task automatic row(input string nm, input logic rst_n, input logic [6:0] op,
                       input logic mr, input logic [9:0] c);
        vecs.push_back('{nm, rst_n, op, mr, c, (rst_n ? exp_ret : 32'd0)});
    endtask

    task automatic rst_row(input string nm);
        row(nm, 1'b0, 7'b0000000, 1'b1, 10'd0);
        exp_ret = 0;
    endtask

    task automatic fd(input string nm, input logic [6:0] op, input logic mr);
        row({nm, ".F"}, 1'b1, op, mr, ctl(1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        row({nm, ".D"}, 1'b1, op, mr, 10'd0);
    endtask

    task automatic alu(input string nm, input logic [6:0] op, input logic imm,
                       input logic [1:0] sel, input logic mr);
        fd(nm, op, mr);
        row({nm, ".EX"}, 1'b1, op, mr, ctl(0, 0, 0, 2'b00, imm, 0, 0, 0, 0));
        row({nm, ".WB"}, 1'b1, op, mr, ctl(0, 1, 0, sel, 0, 1, 0, 0, 0));
        exp_ret++;
    endtask

    task automatic ld(input string nm, input int waits);
        fd(nm, 7'b0000011, 1'b1);
        row({nm, ".EX"}, 1'b1, 7'b0000011, 1'b1, ctl(0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        for (int i = 0; i < waits; i++)
            row({nm, ".MW"}, 1'b1, 7'b0000011, 1'b0, ctl(0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        row({nm, ".MEM"}, 1'b1, 7'b0000011, 1'b1, ctl(0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        row({nm, ".WB"}, 1'b1, 7'b0000011, 1'b1, ctl(0, 1, 0, 2'b00, 0, 1, 0, 0, 0));
        exp_ret++;
    endtask

    task automatic st(input string nm, input int waits);
        fd(nm, 7'b0100011, 1'b1);
        row({nm, ".EX"}, 1'b1, 7'b0100011, 1'b1, ctl(0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        for (int i = 0; i < waits; i++)
            row({nm, ".MW"}, 1'b1, 7'b0100011, 1'b0, ctl(0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        row({nm, ".MEM"}, 1'b1, 7'b0100011, 1'b1, ctl(0, 0, 1, 2'b00, 1, 1, 0, 0, 0));
        exp_ret++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    function automatic logic [9:0] ctl_now();
        return {IR_load, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc,
                pc_next_sel, pc_adder_sel, halted};
    endfunction

    initial begin
        rst_row("rst0");
        rst_row("rst1");
        alu("add", 7'b0110011, 0, 2'b01, 1'b1);
        alu("add_mr0", 7'b0110011, 0, 2'b01, 1'b0);
        alu("addw", 7'b0111011, 0, 2'b01, 1'b1);
        alu("addi", 7'b0010011, 1, 2'b01, 1'b1);
        alu("addiw", 7'b0011011, 1, 2'b01, 1'b0);
        alu("lui", 7'b0110111, 1, 2'b01, 1'b1);
        alu("auipc", 7'b0010111, 1, 2'b11, 1'b1);
        ld("lw_w2", 2);
        st("sw", 0);
        st("sw_w1", 1);
        fd("beq", 7'b1100011, 1'b1);
        row("beq.EX", 1'b1, 7'b1100011, 1'b1, ctl(0, 0, 0, 2'b00, 0, 1, 1, 0, 0));
        exp_ret++;
        fd("jal", 7'b1101111, 1'b0);
        row("jal.EX", 1'b1, 7'b1101111, 1'b0, ctl(0, 1, 0, 2'b10, 1, 1, 1, 0, 0));
        exp_ret++;
        fd("jalr", 7'b1100111, 1'b1);
        row("jalr.EX", 1'b1, 7'b1100111, 1'b1, ctl(0, 1, 0, 2'b10, 1, 1, 1, 1, 0));
        exp_ret++;
        alu("after_jalr", 7'b0110011, 0, 2'b01, 1'b1);
        fd("sys", 7'b1110011, 1'b1);
        for (int i = 0; i < 20; i++)
            row("sys.HALT", 1'b1, (i < 10) ? 7'b1110011 : 7'b0110011, i[0],
                ctl(0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        rst_row("sys.rst");
        fd("ill", 7'b0000000, 1'b1);
        for (int i = 0; i < 20; i++)
            row("ill.HALT", 1'b1, 7'b0000000, 1'b1, ctl(0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        rst_row("ill.rst");
        alu("add2", 7'b0110011, 0, 2'b01, 1'b1);
        alu("add3", 7'b0110011, 0, 2'b01, 1'b1);
        fd("abort_ex", 7'b0110011, 1'b1);
        rst_row("abort_ex.rst");
        fd("after_abort", 7'b0110011, 1'b1);
        row("after_abort.EX", 1'b1, 7'b0110011, 1'b1, 10'd0);
        row("after_abort.WB", 1'b1, 7'b0110011, 1'b1, ctl(0, 1, 0, 2'b01, 0, 1, 0, 0, 0));
        exp_ret++;
        fd("abort_mem", 7'b0100011, 1'b1);
        row("abort_mem.EX", 1'b1, 7'b0100011, 1'b0, ctl(0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        row("abort_mem.MW", 1'b1, 7'b0100011, 1'b0, ctl(0, 0, 0, 2'b00, 1, 0, 0, 0, 0));
        row("abort_mem.rst", 1'b0, 7'b0100011, 1'b1, 10'd0);
        exp_ret = 0;
        row("abort_mem.F", 1'b1, 7'b0100011, 1'b1, ctl(1, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        row("abort_mem.D", 1'b1, 7'b0100011, 1'b1, 10'd0);
        rst_row("end.rst");

        foreach (vecs[i]) begin
            @(posedge CLK);
            #1;
            RST_N     = vecs[i].rst_n;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].mr;
            @(negedge CLK);
            chk({vecs[i].name, ".ctl"}, {22'd0, ctl_now()}, {22'd0, vecs[i].ctl});
            chk({vecs[i].name, ".ret"}, retired, vecs[i].ret);
        end

        // Counter wrap: preset to all-ones, retire one BEQ
        @(posedge CLK);
        #1;
        RST_N     = 1'b1;
        opcode    = 7'b1100011;
        mem_ready = 1'b1;
        dut.r_retired = 32'hFFFF_FFFF;
        @(negedge CLK);
        chk("wrap.pre", retired, 32'hFFFF_FFFF);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("wrap.ex_lpc", {31'd0, load_pc}, 32'd1);
        @(negedge CLK);
        chk("wrap.post", retired, 32'd0);
        chk("wrap.fetch", {31'd0, IR_load}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the RV64I datapath. It decodes the opcode held in the instruction register and walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, driving the datapath control inputs WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc, pc_next_sel and pc_adder_sel, plus a new IR load enable. It sits beside the datapath at top level, receives the opcode from it, and halts the core on illegal or SYSTEM opcodes.

## Interface
- No parameters. Widths are fixed by RV64I.
- CLK  in  1  core clock; all state changes on the rising edge.
- RST_N  in  1  reset, synchronous and active-low.
- opcode  in  7  instruction[6:0] from the IR; valid from DECODE until the instruction retires.
- mem_ready  in  1  data memory done; sampled only in MEMORY. Tie to 1 for the current single-cycle memory.
- IR_load  out  1  IR capture enable; replaces the IR's constant LOAD.
- WE_RF  out  1  regfile write enable.
- WE_MEM  out  1  data memory write enable.
- RF_din_sel  out  2  regfile Din source: 00 DM_out, 01 ula, 10 pc_primary_adder (PC+4), 11 pc_secondary_adder.
- ULA_din2_sel  out  1  ULA operand 2: 0 rs2, 1 extended immediate.
- load_pc  out  1  PC update enable.
- pc_next_sel  out  1  0 sequential (primary adder), 1 target (secondary adder, branch condition resolved in the PC block).
- pc_adder_sel  out  1  secondary adder base: 0 PC+imm, 1 rs1+imm (JALR only).
- halted  out  1  high in HALT.
- retired  out  32  count of retired instructions; wraps at 2^32-1 to 0.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. Reset state is FETCH.
- Outputs are Moore decodes of state and opcode. Any output not listed for a state is 0.
- FETCH: IR_load=1. Next state is DECODE.
- DECODE: classify the opcode; no enables.
  - ILLEGAL or SYSTEM (1110011) goes to HALT.
  - Every other class goes to EXECUTE.
- Instruction classes:
  - ALU-R: 0110011, 0111011.
  - ALU-I: 0010011, 0011011.
  - LOAD: 0000011.
  - STORE: 0100011.
  - BRANCH: 1100011.
  - JAL: 1101111.
  - JALR: 1100111.
  - LUI: 0110111.
  - AUIPC: 0010111.
- EXECUTE:
  - ULA_din2_sel=1 for every class except ALU-R and BRANCH.
  - BRANCH: load_pc=1, pc_next_sel=1, then FETCH. The PC block selects PC+4 when the branch is not taken.
  - JAL: load_pc=1, pc_next_sel=1, WE_RF=1, RF_din_sel=10, then FETCH.
  - JALR: as JAL, plus pc_adder_sel=1.
  - LOAD and STORE go to MEMORY; all other classes go to WRITEBACK.
- MEMORY:
  - ULA_din2_sel=1, so the address stays stable.
  - STORE: WE_MEM=mem_ready.
  - When mem_ready=0, the FSM stays in MEMORY. When mem_ready=1:
    - STORE: load_pc=1, pc_next_sel=0, then FETCH.
    - LOAD: WRITEBACK.
- WRITEBACK: WE_RF=1, load_pc=1, pc_next_sel=0, then FETCH.
  - RF_din_sel: 00 for LOAD, 01 for ALU-R/ALU-I/LUI, 11 for AUIPC.
  - The ULA produces the LUI result from its opcode input.
- HALT: all enables 0, halted=1. Only reset exits.
- retired increments by 1 on every edge where load_pc=1.

## Timing
- Cycles per instruction:
  - BRANCH/JAL/JALR: 3.
  - ALU/LUI/AUIPC: 4.
  - STORE: 4 + wait cycles.
  - LOAD: 5 + wait cycles.
- load_pc is high for exactly one cycle per instruction. WE_RF is high at most one cycle; WE_MEM at most one.
- In JAL/JALR the rd write and the PC load share one edge; rd receives the pre-update PC+4.
- While RST_N=0, all outputs are forced 0 combinationally. On the first edge with RST_N=0: state becomes FETCH, retired becomes 0, halted becomes 0.
- Reset mid-instruction or mid-wait aborts the instruction with no further writes. Datapath reset is handled separately.
- mem_ready outside MEMORY is ignored.

## Structure
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - RF_din_sel encodings (SEL_DM, SEL_ULA, SEL_PC4, SEL_PCIMM);
  - instruction-class enum.
- Sub-module main_decoder: combinational, opcode -> instruction class (ILLEGAL for unlisted opcodes).
- control_unit contains the state register, next-state logic, output decode and retired counter.

## Test plan
- Reset then ADD (0110011), mem_ready=1 → states FETCH,DECODE,EXECUTE,WRITEBACK. WE_RF=1 with RF_din_sel=01 only in cycle 4; load_pc pulses once; retired=1.
- LW with mem_ready low for 2 cycles → MEMORY held 3 cycles; WE_RF (RF_din_sel=00) one cycle later; total 7 cycles; WE_MEM never 1.
- SW → WE_MEM=1 together with load_pc=1 in cycle 4 only; WE_RF stays 0.
- JALR → cycle 3 shows load_pc=1, pc_next_sel=1, pc_adder_sel=1, WE_RF=1, RF_din_sel=10; next cycle is FETCH.
- Opcode 1110011, then 0000000 after reset → HALT after DECODE, halted=1, all enables 0 for 20 cycles; RST_N=0 for one edge returns to FETCH with retired=0.
- Preload retired to 0xFFFFFFFF via a run of ADDs (or force), retire one BEQ → retired=0. Assert RST_N=0 mid-EXECUTE → no write enables at any point after.
